// File: rtl/trail_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trail_pkg                                                                  |
// | Grid geometry, colours, FSM states and cell helpers for trail_collision.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trail_pkg;

    localparam int CELL_LOG2    = 3;
    localparam int PIX_W        = 10;
    localparam int CELL_W       = PIX_W - CELL_LOG2;
    localparam int GRID_W       = 80;
    localparam int GRID_H       = 60;
    localparam int BORDER_CELLS = 2;
    localparam int CELLS        = GRID_W * GRID_H;
    localparam int ADDR_W       = 13;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] HEAD_NONE = '1;
    localparam logic [PIX_W-1:0]  SCREEN_W  = PIX_W'(GRID_W << CELL_LOG2);
    localparam logic [PIX_W-1:0]  SCREEN_H  = PIX_W'(GRID_H << CELL_LOG2);

    localparam logic [7:0] TRAIL_R = 8'd0;
    localparam logic [7:0] TRAIL_G = 8'd255;
    localparam logic [7:0] TRAIL_B = 8'd255;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_RUN     = 2'd1,
        ST_CHECK   = 2'd2,
        ST_CRASHED = 2'd3
    } state_t;

    // Row-major address, cy*80 built from shifts; wraps harmlessly for far-off cells.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CELL_W-1:0] cx,
                                                    input logic [CELL_W-1:0] cy);
        logic [ADDR_W-1:0] y;
        y = ADDR_W'(cy);
        return (y << 6) + (y << 4) + ADDR_W'(cx);
    endfunction

    function automatic logic cell_outside(input logic [CELL_W-1:0] cx,
                                          input logic [CELL_W-1:0] cy);
        return (cx < CELL_W'(BORDER_CELLS)) || (cx > CELL_W'(GRID_W - 1 - BORDER_CELLS)) ||
               (cy < CELL_W'(BORDER_CELLS)) || (cy > CELL_W'(GRID_H - 1 - BORDER_CELLS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/trail_bitmap_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trail_bitmap_ram                                                           |
// | 4800x1 simple dual-port bitmap: port A read/write, port B read-only.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trail_bitmap_ram
    import trail_pkg::*;
(
    input  logic              clk,
    input  logic              i_en_a,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic              i_wdata_a,
    output logic              o_rdata_a,
    input  logic              i_en_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_rdata_b
);

    logic mem [CELLS];

    // Addresses past the last cell are ignored so wrapped addresses never touch memory.
    always_ff @(posedge clk) begin
        if (i_en_a && (i_addr_a < ADDR_W'(CELLS))) begin
            if (i_we_a) begin
                mem[i_addr_a] <= i_wdata_a;
            end
            o_rdata_a <= mem[i_addr_a];
        end
    end

    always_ff @(posedge clk) begin
        if (i_en_b && (i_addr_b < ADDR_W'(CELLS))) begin
            o_rdata_b <= mem[i_addr_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/trail_collision.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trail_collision                                                            |
// | Light-cycle trail bitmap, crash detection and trail pixel colour.          |
// | Optional: TRAIL_HEAD_MARK_EN draws the most recent trail cell in white.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trail_collision
    import trail_pkg::*;
(
    input  logic             VGA_CLK,
    input  logic             reset_n,
    input  logic             clear_req,
    input  logic             step_valid,
    input  logic [PIX_W-1:0] pos_x,
    input  logic [PIX_W-1:0] pos_y,
    input  logic [PIX_W-1:0] next_x,
    input  logic [PIX_W-1:0] next_y,
    output logic             step_ready,
    output logic             busy,
    output logic             collision,
    output logic [7:0]       trail_r,
    output logic [7:0]       trail_g,
    output logic [7:0]       trail_b
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CELL_W-1:0]   cx_q, cx_d;
    logic [CELL_W-1:0]   cy_q, cy_d;
    logic                collision_q, collision_d;
    logic                vis_q, vis_d;

    logic                ram_en_a, ram_we_a, ram_wdata_a, ram_rdata_a;
    logic [ADDR_W-1:0]   ram_addr_a;
    logic                ram_rdata_b;

    logic [CELL_W-1:0]   w_step_cx, w_step_cy;
    logic [ADDR_W-1:0]   w_step_addr, w_disp_addr;
    logic                w_disp_in, w_head_white;
    logic                unused_pos_bits;

    assign w_step_cx   = pos_x[PIX_W-1:CELL_LOG2];
    assign w_step_cy   = pos_y[PIX_W-1:CELL_LOG2];
    assign w_step_addr = cell_addr(w_step_cx, w_step_cy);
    assign w_disp_in   = (next_x < SCREEN_W) && (next_y < SCREEN_H);
    assign w_disp_addr = cell_addr(next_x[PIX_W-1:CELL_LOG2], next_y[PIX_W-1:CELL_LOG2]);
    assign unused_pos_bits = ^{pos_x[CELL_LOG2-1:0], pos_y[CELL_LOG2-1:0]};

    assign busy       = (state_q == ST_CLEAR);
    assign step_ready = (state_q == ST_RUN);
    assign collision  = collision_q;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        addr_d      = addr_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        collision_d = collision_q;
        ram_en_a    = 1'b0;
        ram_we_a    = 1'b0;
        ram_wdata_a = 1'b0;
        ram_addr_a  = addr_q;
        vis_d       = w_disp_in && (state_q != ST_CLEAR);

        if (clear_req) begin
            state_d     = ST_CLEAR;
            clr_addr_d  = '0;
            collision_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ram_en_a   = 1'b1;
                    ram_we_a   = 1'b1;
                    ram_addr_a = clr_addr_q;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step_valid) begin
                        cx_d       = w_step_cx;
                        cy_d       = w_step_cy;
                        addr_d     = w_step_addr;
                        ram_en_a   = 1'b1;
                        ram_addr_a = w_step_addr;
                        state_d    = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Read data for the latched cell is valid this cycle.
                    if (cell_outside(cx_q, cy_q) || ram_rdata_a) begin
                        collision_d = 1'b1;
                        state_d     = ST_CRASHED;
                    end else begin
                        ram_en_a    = 1'b1;
                        ram_we_a    = 1'b1;
                        ram_wdata_a = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                ST_CRASHED: begin
                    state_d = ST_CRASHED;
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            addr_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            collision_q <= 1'b0;
            vis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            addr_q      <= addr_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            collision_q <= collision_d;
            vis_q       <= vis_d;
        end
    end

`ifdef TRAIL_HEAD_MARK_EN
    logic [ADDR_W-1:0] head_q, head_d;
    logic              is_head_q, is_head_d;
    logic              w_commit;

    assign w_commit = ram_we_a && ram_wdata_a;

    always_comb begin
        head_d    = head_q;
        is_head_d = (w_disp_addr == head_q);
        if (state_q == ST_CLEAR) begin
            head_d = HEAD_NONE;
        end else if (w_commit) begin
            head_d = addr_q;
        end
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= HEAD_NONE;
            is_head_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            is_head_q <= is_head_d;
        end
    end

    assign w_head_white = is_head_q;
`else
    assign w_head_white = 1'b0;
`endif

    always_comb begin
        trail_r = 8'd0;
        trail_g = 8'd0;
        trail_b = 8'd0;
        if (vis_q && ram_rdata_b) begin
            if (w_head_white) begin
                trail_r = 8'd255;
                trail_g = 8'd255;
                trail_b = 8'd255;
            end else begin
                trail_r = TRAIL_R;
                trail_g = TRAIL_G;
                trail_b = TRAIL_B;
            end
        end
    end

    trail_bitmap_ram u_bitmap (
        .clk       (VGA_CLK),
        .i_en_a    (ram_en_a),
        .i_we_a    (ram_we_a),
        .i_addr_a  (ram_addr_a),
        .i_wdata_a (ram_wdata_a),
        .o_rdata_a (ram_rdata_a),
        .i_en_b    (w_disp_in),
        .i_addr_b  (w_disp_addr),
        .o_rdata_b (ram_rdata_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_trail_collision.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trail_collision                                                         |
// | Self-checking bench: cell-level game model compared every cycle.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trail_collision;

`ifdef TRAIL_HEAD_MARK_EN
    localparam bit HEAD_MARK = 1'b1;
`else
    localparam bit HEAD_MARK = 1'b0;
`endif

    logic       VGA_CLK    = 1'b0;
    logic       reset_n    = 1'b1;
    logic       clear_req  = 1'b0;
    logic       step_valid = 1'b0;
    logic [9:0] pos_x  = '0;
    logic [9:0] pos_y  = '0;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic       step_ready, busy, collision;
    logic [7:0] trail_r, trail_g, trail_b;

    int checks = 0;
    int errors = 0;
    bit cmp_on    = 1'b0;
    bit rand_disp = 1'b0;

    // Game model: cycles of clearing left, one pending step, crash flag, cell map.
    int   clear_left = 4800;
    bit   pending    = 1'b0;
    bit   crashed    = 1'b0;
    int   pcx = 0, pcy = 0;
    int   hx = -1, hy = -1;
    int   dx, dy;
    bit   bm [128][128];
    bit   exp_busy = 1'b1, exp_ready = 1'b0, exp_coll = 1'b0;
    logic [7:0] exp_r = '0, exp_g = '0, exp_b = '0;

    trail_collision dut (
        .VGA_CLK    (VGA_CLK),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .step_valid (step_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .next_x     (next_x),
        .next_y     (next_y),
        .step_ready (step_ready),
        .busy       (busy),
        .collision  (collision),
        .trail_r    (trail_r),
        .trail_g    (trail_g),
        .trail_b    (trail_b)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_clear();
        clear_left = 4800;
        pending    = 1'b0;
        crashed    = 1'b0;
        hx = -1;
        hy = -1;
        foreach (bm[i, j]) bm[i][j] = 1'b0;
    endfunction

    always @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
            exp_busy = 1'b1; exp_ready = 1'b0; exp_coll = 1'b0;
            exp_r = '0; exp_g = '0; exp_b = '0;
        end else begin
            // Display sees the map as it was before this edge.
            dx = int'(next_x) / 8;
            dy = int'(next_y) / 8;
            exp_r = '0; exp_g = '0; exp_b = '0;
            if (next_x < 640 && next_y < 480 && clear_left == 0 && bm[dx][dy]) begin
                if (HEAD_MARK && dx == hx && dy == hy) begin
                    exp_r = 8'd255; exp_g = 8'd255; exp_b = 8'd255;
                end else begin
                    exp_r = 8'd0; exp_g = 8'd255; exp_b = 8'd255;
                end
            end
            if (clear_req) begin
                model_clear();
            end else if (clear_left > 0) begin
                clear_left--;
            end else if (pending) begin
                pending = 1'b0;
                if (pcx < 2 || pcx > 77 || pcy < 2 || pcy > 57 || bm[pcx][pcy]) begin
                    crashed = 1'b1;
                end else begin
                    bm[pcx][pcy] = 1'b1;
                    hx = pcx;
                    hy = pcy;
                end
            end else if (!crashed && step_valid) begin
                pending = 1'b1;
                pcx = int'(pos_x) / 8;
                pcy = int'(pos_y) / 8;
            end
            exp_busy  = (clear_left > 0);
            exp_ready = !exp_busy && !pending && !crashed;
            exp_coll  = crashed;
        end
    end

    always @(negedge VGA_CLK) begin
        if (cmp_on) begin
            check("busy", busy, exp_busy);
            check("step_ready", step_ready, exp_ready);
            check("collision", collision, exp_coll);
            check("trail_rgb", {trail_r, trail_g, trail_b}, {exp_r, exp_g, exp_b});
        end
    end

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
        if (rand_disp) begin
            if ($urandom_range(0, 1) == 1) begin
                next_x = 10'($urandom_range(0, 700));
                next_y = 10'($urandom_range(0, 520));
            end else begin
                next_x = 10'($urandom_range(0, 250));
                next_y = 10'($urandom_range(0, 250));
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic step(input int x, input int y);
        step_valid = 1'b1;
        pos_x = 10'(x);
        pos_y = 10'(y);
        tick();
        step_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic show(input int x, input int y);
        next_x = 10'(x);
        next_y = 10'(y);
        tick();
    endtask

    initial begin
        #1 reset_n = 1'b0;
        cmp_on = 1'b1;
        repeat (3) @(posedge VGA_CLK);
        #1 reset_n = 1'b1;
        check("rst_busy", busy, 1);
        check("rst_ready", step_ready, 0);
        check("rst_collision", collision, 0);
        check("rst_trail", {trail_r, trail_g, trail_b}, 0);

        // Initial clear with ignored steps and random display scan.
        rand_disp = 1'b1;
        for (int i = 0; i < 4799; i++) begin
            step_valid = ($urandom_range(0, 1) == 1);
            pos_x = 10'($urandom_range(16, 600));
            pos_y = 10'($urandom_range(16, 400));
            tick();
        end
        step_valid = 1'b0;
        check("clear_last_busy", busy, 1);
        tick();
        check("clear_done_busy", busy, 0);
        check("clear_done_ready", step_ready, 1);
        check("clear_done_collision", collision, 0);

        // Two trail cells, then display them.
        rand_disp = 1'b0;
        step(219, 239);
        check("ready_in_check", step_ready, 0);
        tick();
        step(100, 100);
        tick();
        show(220, 235);
        check("trail_27_29_g", trail_g, 255);
        check("trail_27_29_b", trail_b, 255);
        check("trail_27_29_r", trail_r, 0);
        show(100, 100);
        check("trail_12_12_r", trail_r, HEAD_MARK ? 255 : 0);
        check("trail_12_12_g", trail_g, 255);
        show(700, 235);
        check("offscreen_g", trail_g, 0);
        for (int y = 224; y < 248; y++) begin
            for (int x = 208; x < 232; x++) begin
                show(x, y);
            end
        end

        // Revisit an occupied cell.
        step(219, 239);
        check("revisit_not_yet", collision, 0);
        tick();
        check("revisit_crash", collision, 1);
        check("crashed_ready", step_ready, 0);
        step(300, 300);
        tick();
        check("crashed_sticky", collision, 1);
        show(300, 300);
        check("crashed_no_write", trail_g, 0);

        // Clear restarted part-way.
        rand_disp = 1'b1;
        do_clear();
        check("clear_collision_low", collision, 0);
        ticks(2000);
        do_clear();
        ticks(4799);
        check("restart_busy_still", busy, 1);
        tick();
        check("restart_busy_done", busy, 0);

        // clear_req wins over a simultaneous step.
        rand_disp = 1'b0;
        step_valid = 1'b1;
        clear_req  = 1'b1;
        pos_x = 10'd300;
        pos_y = 10'd300;
        tick();
        step_valid = 1'b0;
        clear_req  = 1'b0;
        check("coincident_busy", busy, 1);
        ticks(4800);
        check("coincident_done", busy, 0);
        show(300, 300);
        check("coincident_no_write", trail_g, 0);

        // Playable edge cells, then out-of-bounds steps.
        step(16, 16);
        tick();
        check("edge_min_ok", collision, 0);
        step(623, 463);
        tick();
        check("edge_max_ok", collision, 0);
        step(8, 100);
        tick();
        check("oob_left", collision, 1);
        show(8, 100);
        check("oob_left_no_write", trail_g, 0);
        do_clear();
        ticks(4800);
        step(1019, 100);
        tick();
        check("oob_wrap", collision, 1);
        do_clear();
        ticks(4800);

        // Randomized play.
        rand_disp = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            step_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                pos_x = 10'($urandom);
                pos_y = 10'($urandom);
            end else begin
                pos_x = 10'($urandom_range(16, 120));
                pos_y = 10'($urandom_range(16, 120));
            end
            clear_req = (collision && $urandom_range(0, 39) == 0) ||
                        ($urandom_range(0, 2999) == 0);
            tick();
        end
        step_valid = 1'b0;
        clear_req  = 1'b0;

        // Asynchronous reset while a check is pending.
        do_clear();
        ticks(4800);
        rand_disp = 1'b0;
        step(219, 239);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1);
        check("async_rst_ready", step_ready, 0);
        check("async_rst_collision", collision, 0);
        check("async_rst_trail", {trail_r, trail_g, trail_b}, 0);
        @(posedge VGA_CLK);
        #1 reset_n = 1'b1;
        ticks(4799);
        check("post_rst_busy", busy, 1);
        tick();
        check("post_rst_done", busy, 0);
        show(220, 235);
        check("post_rst_no_trail", trail_g, 0);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
